// File: rtl/qdec_pkg.sv
// Shared definitions for the quadrature decoder: decode-mode codes, {A,B} Gray states
// and the classification of a previous->current transition.
package qdec_pkg;

  localparam logic [1:0] QDEC_MODE_X1 = 2'd0;
  localparam logic [1:0] QDEC_MODE_X2 = 2'd1;
  localparam logic [1:0] QDEC_MODE_X4 = 2'd2;

  // {A,B} states in forward rotation order; reverse walks the list backwards.
  localparam logic [1:0] QDEC_GRAY_0 = 2'b00;
  localparam logic [1:0] QDEC_GRAY_1 = 2'b01;
  localparam logic [1:0] QDEC_GRAY_2 = 2'b11;
  localparam logic [1:0] QDEC_GRAY_3 = 2'b10;

  typedef enum logic [1:0] {
    STEP_NONE    = 2'd0,
    STEP_PLUS    = 2'd1,
    STEP_MINUS   = 2'd2,
    STEP_ILLEGAL = 2'd3
  } qdec_step_e;

  function automatic logic [1:0] gray_fwd(input logic [1:0] ab);
    logic [1:0] nxt;
    case (ab)
      QDEC_GRAY_0: nxt = QDEC_GRAY_1;
      QDEC_GRAY_1: nxt = QDEC_GRAY_2;
      QDEC_GRAY_2: nxt = QDEC_GRAY_3;
      default:     nxt = QDEC_GRAY_0;
    endcase
    return nxt;
  endfunction

  function automatic qdec_step_e step_dir(input logic [1:0] prev_ab, input logic [1:0] cur_ab);
    qdec_step_e res;
    if (prev_ab == cur_ab)
      res = STEP_NONE;
    else if ((prev_ab ^ cur_ab) == 2'b11)
      res = STEP_ILLEGAL;
    else if (gray_fwd(prev_ab) == cur_ab)
      res = STEP_PLUS;
    else
      res = STEP_MINUS;
    return res;
  endfunction

endpackage

// File: rtl/qdec_chan.sv
// One decoder channel: 2-FF synchroniser, per-input glitch filter, Gray decode, wrapping
// counter and sticky error. QDEC_INDEX_EN adds the Z input with index clear and pulse.
module qdec_chan
  import qdec_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int FILT_LEN = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [1:0]       i_mode,
  input  logic             i_coder_A,
  input  logic             i_coder_B,
`ifdef QDEC_INDEX_EN
  input  logic             i_coder_Z,
  output logic             o_index_pulse,
`endif
  input  logic             i_clr,
  input  logic             i_err_clr,
  output logic             o_plus_pulse,
  output logic             o_minus_pulse,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_err
);

`ifdef QDEC_INDEX_EN
  localparam int NSIG = 3;
`else
  localparam int NSIG = 2;
`endif
  localparam logic [3:0] FILT_LAST = 4'(FILT_LEN - 1);

  logic [NSIG-1:0]      w_pin;
  logic [NSIG-1:0]      r_sync1;
  logic [NSIG-1:0]      r_sync2;
  logic [NSIG-1:0]      r_filt;
  logic [NSIG-1:0][3:0] r_fcnt;
  logic                 r_primed;
  logic [3:0]           r_pcnt;
  logic [1:0]           r_prev;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_plus;
  logic                 r_minus;
  logic                 r_err;
  logic [1:0]           w_cur;
  qdec_step_e           w_step;
  logic                 w_count_en;
  logic                 w_plus;
  logic                 w_minus;
  logic                 w_illegal;
  logic                 w_zero;

`ifdef QDEC_INDEX_EN
  logic r_z_prev;
  logic r_index;
  logic w_z_rise;
  assign w_pin    = {i_coder_Z, i_coder_A, i_coder_B};
  assign w_z_rise = r_filt[2] & ~r_z_prev;
  assign o_index_pulse = r_index;
`else
  assign w_pin = {i_coder_A, i_coder_B};
`endif
  assign w_cur = r_filt[1:0];

  // Bit 0 = B, bit 1 = A, bit 2 = Z. A filtered bit follows its synchroniser only after
  // FILT_LEN consecutive differing samples; any agreement restarts the count.
  // NOTE: every clocked register uses <= so all updates see pre-edge values.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
      r_filt  <= '1;
      r_fcnt  <= '0;
    end else begin
      r_sync1 <= w_pin;
      r_sync2 <= r_sync1;
      for (int i = 0; i < NSIG; i++) begin
        if (r_sync2[i] == r_filt[i]) begin
          r_fcnt[i] <= '0;
        end else if (r_fcnt[i] == FILT_LAST) begin
          r_filt[i] <= r_sync2[i];
          r_fcnt[i] <= '0;
        end else begin
          r_fcnt[i] <= r_fcnt[i] + 4'd1;
        end
      end
    end
  end

  // Until primed, wait for {A,B} to sit quietly for FILT_LEN cycles and adopt it silently.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_primed <= 1'b0;
      r_pcnt   <= '0;
      r_prev   <= '0;
    end else if (!r_primed) begin
      if (r_sync2[1:0] != r_filt[1:0]) begin
        r_pcnt <= '0;
      end else if (r_pcnt == FILT_LAST) begin
        r_primed <= 1'b1;
        r_prev   <= w_cur;
      end else begin
        r_pcnt <= r_pcnt + 4'd1;
      end
    end else begin
      r_prev <= w_cur;
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_step     = step_dir(r_prev, w_cur);
    w_count_en = 1'b0;
    case (i_mode)
      QDEC_MODE_X4: w_count_en = 1'b1;
      QDEC_MODE_X2: w_count_en = r_prev[0] ^ w_cur[0];
      default:      w_count_en = ~r_prev[0] & w_cur[0];
    endcase
    w_plus    = r_primed && w_count_en && (w_step == STEP_PLUS);
    w_minus   = r_primed && w_count_en && (w_step == STEP_MINUS);
    w_illegal = r_primed && (w_step == STEP_ILLEGAL);
`ifdef QDEC_INDEX_EN
    w_zero    = i_clr | w_z_rise;
`else
    w_zero    = i_clr;
`endif
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt   <= '0;
      r_plus  <= 1'b0;
      r_minus <= 1'b0;
      r_err   <= 1'b0;
`ifdef QDEC_INDEX_EN
      r_z_prev <= 1'b1;
      r_index  <= 1'b0;
`endif
    end else begin
      r_plus  <= w_plus;
      r_minus <= w_minus;
      if (w_zero)
        r_cnt <= '0;
      else if (w_plus)
        r_cnt <= r_cnt + CNT_W'(1);
      else if (w_minus)
        r_cnt <= r_cnt - CNT_W'(1);
      // A fresh error outranks a clear arriving in the same cycle.
      if (w_illegal)
        r_err <= 1'b1;
      else if (i_err_clr)
        r_err <= 1'b0;
`ifdef QDEC_INDEX_EN
      r_z_prev <= r_filt[2];
      r_index  <= w_z_rise;
`endif
    end
  end

  assign o_plus_pulse  = r_plus;
  assign o_minus_pulse = r_minus;
  assign o_cnt         = r_cnt;
  assign o_err         = r_err;

endmodule

// File: rtl/quad_decoder_mc.sv
// Multi-channel quadrature decoder: CH_NUM independent qdec_chan instances sharing one mode.
// QDEC_INDEX_EN adds per-channel i_coder_Z / o_index_pulse.
module quad_decoder_mc #(
  parameter int CH_NUM   = 4,
  parameter int CNT_W    = 16,
  parameter int FILT_LEN = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [1:0]              i_mode,
  input  logic [CH_NUM-1:0]       i_coder_A,
  input  logic [CH_NUM-1:0]       i_coder_B,
`ifdef QDEC_INDEX_EN
  input  logic [CH_NUM-1:0]       i_coder_Z,
  output logic [CH_NUM-1:0]       o_index_pulse,
`endif
  input  logic [CH_NUM-1:0]       i_clr,
  input  logic [CH_NUM-1:0]       i_err_clr,
  output logic [CH_NUM-1:0]       o_plus_pulse,
  output logic [CH_NUM-1:0]       o_minus_pulse,
  output logic [CH_NUM*CNT_W-1:0] o_cnt,
  output logic [CH_NUM-1:0]       o_err
);

  for (genvar g = 0; g < CH_NUM; g++) begin : g_chan
    qdec_chan #(
      .CNT_W    (CNT_W),
      .FILT_LEN (FILT_LEN)
    ) u_chan (
      .i_clk         (i_clk),
      .i_rst_n       (i_rst_n),
      .i_mode        (i_mode),
      .i_coder_A     (i_coder_A[g]),
      .i_coder_B     (i_coder_B[g]),
`ifdef QDEC_INDEX_EN
      .i_coder_Z     (i_coder_Z[g]),
      .o_index_pulse (o_index_pulse[g]),
`endif
      .i_clr         (i_clr[g]),
      .i_err_clr     (i_err_clr[g]),
      .o_plus_pulse  (o_plus_pulse[g]),
      .o_minus_pulse (o_minus_pulse[g]),
      .o_cnt         (o_cnt[g*CNT_W +: CNT_W]),
      .o_err         (o_err[g])
    );
  end

endmodule

// File: tb/tb_quad_decoder_mc.sv
// Self-checking bench for quad_decoder_mc: step table on ch0, directed corner sequences,
// then randomized motion against a pin-level model (fixed latency, Gray-position arithmetic).
module tb_quad_decoder_mc;

  localparam int CH  = 4;
  localparam int CW  = 16;
  localparam int FL  = 4;
  localparam int LAT = 2 + FL + 1;
  localparam logic [1:0] X1 = 2'd0, X2 = 2'd1, X4 = 2'd2, XR = 2'd3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [1:0]      mode = 2'd0;
  logic [CH-1:0]   coder_a = '0, coder_b = '0, clr = '0, err_clr = '0;
  logic [CH-1:0]   plus, minus, err;
  logic [CH*CW-1:0] cnt;
`ifdef QDEC_INDEX_EN
  logic [CH-1:0]   coder_z = '0;
  logic [CH-1:0]   index_pulse;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int pulses;

  typedef struct {
    logic [1:0]    mode;
    logic [1:0]    ab;
    logic          plus;
    logic          minus;
    logic          err;
    logic [CW-1:0] cnt;
  } vec_t;
  vec_t vecs [33];

  logic [1:0]    gray_seq [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
  logic [1:0]    m_ab  [CH];
  logic [CW-1:0] m_cnt [CH];
  logic          m_err [CH];
  int            hold  [CH];
  int            ring_w   [16][CH];
  bit            ring_ill [16][CH];
  logic [CH-1:0]    exp_p, exp_m, exp_e;
  logic [CH*CW-1:0] exp_cnt;
  logic [1:0]    nxt;
  int            r, slot, pos;

  quad_decoder_mc #(.CH_NUM(CH), .CNT_W(CW), .FILT_LEN(FL)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_mode        (mode),
    .i_coder_A     (coder_a),
    .i_coder_B     (coder_b),
`ifdef QDEC_INDEX_EN
    .i_coder_Z     (coder_z),
    .o_index_pulse (index_pulse),
`endif
    .i_clr         (clr),
    .i_err_clr     (err_clr),
    .o_plus_pulse  (plus),
    .o_minus_pulse (minus),
    .o_cnt         (cnt),
    .o_err         (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got 0x%0h, want 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic set_ab(input int ch, input logic [1:0] ab);
    coder_a[ch] = ab[1];
    coder_b[ch] = ab[0];
  endtask

  function automatic logic [CW-1:0] cnt_of(input int ch);
    return cnt[ch*CW +: CW];
  endfunction

  function automatic int gray_pos(input logic [1:0] ab);
    case (ab)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  // Signed count contribution of a legal move under a mode (0 when not counted).
  function automatic int step_weight(input logic [1:0] md, input logic [1:0] from, input logic [1:0] to);
    int dir;
    dir = (((gray_pos(to) - gray_pos(from) + 4) % 4) == 1) ? 1 : -1;
    if (md == X4) return dir;
    if (md == X2) return (from[0] != to[0]) ? dir : 0;
    if (!from[0] && to[0]) return to[1] ? -1 : 1;
    return 0;
  endfunction

  initial begin
    vecs[0]  = '{X4, 2'b01, 1'b1, 1'b0, 1'b0, 16'd1};
    vecs[1]  = '{X4, 2'b11, 1'b1, 1'b0, 1'b0, 16'd2};
    vecs[2]  = '{X4, 2'b10, 1'b1, 1'b0, 1'b0, 16'd3};
    vecs[3]  = '{X4, 2'b00, 1'b1, 1'b0, 1'b0, 16'd4};
    vecs[4]  = '{X1, 2'b01, 1'b1, 1'b0, 1'b0, 16'd5};
    vecs[5]  = '{X1, 2'b11, 1'b0, 1'b0, 1'b0, 16'd5};
    vecs[6]  = '{X1, 2'b10, 1'b0, 1'b0, 1'b0, 16'd5};
    vecs[7]  = '{X1, 2'b00, 1'b0, 1'b0, 1'b0, 16'd5};
    vecs[8]  = '{X2, 2'b10, 1'b0, 1'b0, 1'b0, 16'd5};
    vecs[9]  = '{X2, 2'b11, 1'b0, 1'b1, 1'b0, 16'd4};
    vecs[10] = '{X2, 2'b01, 1'b0, 1'b0, 1'b0, 16'd4};
    vecs[11] = '{X2, 2'b00, 1'b0, 1'b1, 1'b0, 16'd3};
    vecs[12] = '{X4, 2'b10, 1'b0, 1'b1, 1'b0, 16'd2};
    vecs[13] = '{X4, 2'b11, 1'b0, 1'b1, 1'b0, 16'd1};
    vecs[14] = '{X4, 2'b01, 1'b0, 1'b1, 1'b0, 16'd0};
    vecs[15] = '{X4, 2'b00, 1'b0, 1'b1, 1'b0, 16'hFFFF};
    vecs[16] = '{X4, 2'b01, 1'b1, 1'b0, 1'b0, 16'd0};
    vecs[17] = '{X4, 2'b00, 1'b0, 1'b1, 1'b0, 16'hFFFF};
    vecs[18] = '{X1, 2'b10, 1'b0, 1'b0, 1'b0, 16'hFFFF};
    vecs[19] = '{X1, 2'b11, 1'b0, 1'b1, 1'b0, 16'hFFFE};
    vecs[20] = '{X1, 2'b01, 1'b0, 1'b0, 1'b0, 16'hFFFE};
    vecs[21] = '{X1, 2'b00, 1'b0, 1'b0, 1'b0, 16'hFFFE};
    vecs[22] = '{XR, 2'b01, 1'b1, 1'b0, 1'b0, 16'hFFFF};
    vecs[23] = '{XR, 2'b11, 1'b0, 1'b0, 1'b0, 16'hFFFF};
    vecs[24] = '{XR, 2'b10, 1'b0, 1'b0, 1'b0, 16'hFFFF};
    vecs[25] = '{XR, 2'b00, 1'b0, 1'b0, 1'b0, 16'hFFFF};
    vecs[26] = '{X2, 2'b01, 1'b1, 1'b0, 1'b0, 16'd0};
    vecs[27] = '{X2, 2'b11, 1'b0, 1'b0, 1'b0, 16'd0};
    vecs[28] = '{X2, 2'b10, 1'b1, 1'b0, 1'b0, 16'd1};
    vecs[29] = '{X2, 2'b00, 1'b0, 1'b0, 1'b0, 16'd1};
    vecs[30] = '{X4, 2'b11, 1'b0, 1'b0, 1'b1, 16'd1};
    vecs[31] = '{X4, 2'b10, 1'b1, 1'b0, 1'b1, 16'd2};
    vecs[32] = '{X4, 2'b00, 1'b1, 1'b0, 1'b1, 16'd3};

    // Reset state
    rst_n = 1'b0;
    repeat (3) tick();
    check("reset_cnt", 64'(cnt), 64'd0);
    check("reset_pulses", 64'({plus, minus}), 64'd0);
    check("reset_err", 64'(err), 64'd0);
    rst_n = 1'b1;
    repeat (20) tick();
    check("prime_quiet", 64'({plus, minus, err}), 64'd0);

    // Step table on ch0: exact latency, pulse width, count and error
    for (int i = 0; i < 33; i++) begin
      mode = vecs[i].mode;
      set_ab(0, vecs[i].ab);
      repeat (LAT - 1) tick();
      check($sformatf("v%0d_early", i), 64'({plus[0], minus[0]}), 64'd0);
      tick();
      check($sformatf("v%0d_pulse", i), 64'({plus[0], minus[0]}), 64'({vecs[i].plus, vecs[i].minus}));
      check($sformatf("v%0d_cnt", i), 64'(cnt_of(0)), 64'(vecs[i].cnt));
      check($sformatf("v%0d_err", i), 64'(err[0]), 64'(vecs[i].err));
      tick();
      check($sformatf("v%0d_width", i), 64'({plus[0], minus[0]}), 64'd0);
      repeat (2) tick();
    end

    // Glitch shorter than the filter, then a stable change
    mode = X4;
    err_clr[0] = 1'b1; tick(); err_clr[0] = 1'b0;
    check("err_clr_plain", 64'(err[0]), 64'd0);
    coder_b[0] = 1'b1;
    repeat (FL - 1) tick();
    coder_b[0] = 1'b0;
    pulses = 0;
    repeat (15) begin tick(); pulses += $countones({plus, minus}); end
    check("glitch_pulses", 64'(pulses), 64'd0);
    check("glitch_cnt", 64'(cnt_of(0)), 64'd3);
    coder_b[0] = 1'b1;
    pulses = 0;
    repeat (12) begin tick(); pulses += $countones({plus, minus}); end
    check("stable_pulses", 64'(pulses), 64'd1);
    check("stable_cnt", 64'(cnt_of(0)), 64'd4);
    coder_b[0] = 1'b0;
    repeat (10) tick();
    check("back_cnt", 64'(cnt_of(0)), 64'd3);

    // Illegal 00->11, then a second illegal step against a coincident error clear
    set_ab(0, 2'b11);
    repeat (LAT) tick();
    check("ill1_err", 64'(err[0]), 64'd1);
    check("ill1_pulses", 64'({plus[0], minus[0]}), 64'd0);
    check("ill1_cnt", 64'(cnt_of(0)), 64'd3);
    repeat (3) tick();
    set_ab(0, 2'b00);
    repeat (LAT - 1) tick();
    err_clr[0] = 1'b1; tick(); err_clr[0] = 1'b0;
    check("ill2_err_wins", 64'(err[0]), 64'd1);
    check("ill2_cnt", 64'(cnt_of(0)), 64'd3);
    tick();
    err_clr[0] = 1'b1; tick(); err_clr[0] = 1'b0;
    check("err_clr_after", 64'(err[0]), 64'd0);

    // Clear on ch1 coincident with a plus step; ch2 steps in the same cycle
    for (int k = 1; k <= 5; k++) begin set_ab(1, gray_seq[k % 4]); repeat (8) tick(); end
    check("ch1_cnt5", 64'(cnt_of(1)), 64'd5);
    set_ab(1, 2'b11);
    set_ab(2, 2'b01);
    repeat (LAT - 1) tick();
    clr[1] = 1'b1; tick(); clr[1] = 1'b0;
    check("clr_pulses", 64'(plus), 64'(4'b0110));
    check("clr_ch1_cnt", 64'(cnt_of(1)), 64'd0);
    check("clr_ch2_cnt", 64'(cnt_of(2)), 64'd1);
    check("clr_ch0_cnt", 64'(cnt_of(0)), 64'd3);
    repeat (3) tick();

`ifdef QDEC_INDEX_EN
    // Index: Z rising zeroes ch3 with the same latency as A/B
    for (int k = 1; k <= 37; k++) begin set_ab(3, gray_seq[k % 4]); repeat (8) tick(); end
    check("ch3_cnt37", 64'(cnt_of(3)), 64'd37);
    coder_z[3] = 1'b1;
    repeat (LAT - 1) tick();
    check("idx_early", 64'(index_pulse), 64'd0);
    tick();
    check("idx_pulse", 64'(index_pulse), 64'(4'b1000));
    check("idx_cnt", 64'(cnt_of(3)), 64'd0);
    tick();
    check("idx_width", 64'(index_pulse), 64'd0);
    repeat (3) tick();
`endif

    // Reset in mid-motion: nothing may come out after release
    set_ab(0, 2'b10);
    repeat (3) tick();
    rst_n = 1'b0;
    repeat (2) tick();
    check("midrst_cnt", 64'(cnt), 64'd0);
    rst_n = 1'b1;
    pulses = 0;
    repeat (20) begin
      tick();
      pulses += $countones({plus, minus});
`ifdef QDEC_INDEX_EN
      pulses += $countones(index_pulse);
`endif
    end
    check("midrst_pulses", 64'(pulses), 64'd0);
    check("midrst_err", 64'(err), 64'd0);

    // Randomized motion per mode against the pin-level model
    rst_n = 1'b0;
    coder_a = '0; coder_b = '0; clr = '0; err_clr = '0;
`ifdef QDEC_INDEX_EN
    coder_z = '0;
`endif
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (20) tick();
    for (int ch = 0; ch < CH; ch++) begin
      m_ab[ch] = 2'b00; m_cnt[ch] = '0; m_err[ch] = 1'b0; hold[ch] = 0;
    end
    for (int s = 0; s < 16; s++)
      for (int ch = 0; ch < CH; ch++) begin ring_w[s][ch] = 0; ring_ill[s][ch] = 1'b0; end

    for (int seg = 0; seg < 4; seg++) begin
      mode = 2'(seg);
      for (int c = 0; c < 600; c++) begin
        for (int ch = 0; ch < CH; ch++) begin
          clr[ch]     = ($urandom_range(63) == 0);
          err_clr[ch] = ($urandom_range(31) == 0);
          hold[ch]++;
          if (c < 570 && hold[ch] >= 6 && $urandom_range(3) == 0) begin
            r    = int'($urandom_range(15));
            pos  = gray_pos(m_ab[ch]);
            slot = (cyc + LAT) % 16;
            if (r == 0) begin
              nxt = m_ab[ch] ^ 2'b11;
              ring_ill[slot][ch] = 1'b1;
            end else begin
              nxt = (r < 9) ? gray_seq[(pos + 1) % 4] : gray_seq[(pos + 3) % 4];
              ring_w[slot][ch] = step_weight(mode, m_ab[ch], nxt);
            end
            m_ab[ch] = nxt;
            set_ab(ch, nxt);
            hold[ch] = 0;
          end
        end
        tick();
        slot = cyc % 16;
        for (int ch = 0; ch < CH; ch++) begin
          exp_p[ch] = ring_w[slot][ch] > 0;
          exp_m[ch] = ring_w[slot][ch] < 0;
          if (clr[ch])
            m_cnt[ch] = '0;
          else
            m_cnt[ch] = m_cnt[ch] + CW'(ring_w[slot][ch]);
          if (ring_ill[slot][ch])
            m_err[ch] = 1'b1;
          else if (err_clr[ch])
            m_err[ch] = 1'b0;
          exp_e[ch] = m_err[ch];
          exp_cnt[ch*CW +: CW] = m_cnt[ch];
          ring_w[slot][ch]   = 0;
          ring_ill[slot][ch] = 1'b0;
        end
        check($sformatf("rand_m%0d_pulses", seg), 64'({plus, minus}), 64'({exp_p, exp_m}));
        check($sformatf("rand_m%0d_cnt", seg), 64'(cnt), 64'(exp_cnt));
        check($sformatf("rand_m%0d_err", seg), 64'(err), 64'(exp_e));
      end
    end
    clr = '0;
    err_clr = '0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/quad_decoder_mc.md
Name: quad_decoder_mc

Overview:
- Multi-channel quadrature (A/B) encoder decoder. Parametrised successor of the single-channel B-edge coder.
- Per channel: input synchronisation, glitch filter, selectable x1/x2/x4 decoding, a wrapping position counter and sticky illegal-transition error.
- Sits between the encoder input pins and the AXI4 register block. The register block reads the counts and errors and drives clear/mode.

Parameters:
- CH_NUM, 4, number of encoder channels (1..16)
- CNT_W, 16, position counter width per channel (8..32)
- FILT_LEN, 4, consecutive stable cycles required before a filtered input changes (1..15)

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  reset, synchronous, active-low
- i_mode  in  2  decode mode for all channels: 0=x1, 1=x2, 2=x4, 3=reserved (behaves as x1)
- i_coder_A  in  CH_NUM  encoder A per channel, asynchronous
- i_coder_B  in  CH_NUM  encoder B per channel, asynchronous
- i_clr  in  CH_NUM  per-channel counter clear, one-cycle strobe
- i_err_clr  in  CH_NUM  per-channel error clear, one-cycle strobe
- o_plus_pulse  out  CH_NUM  one-cycle forward-step pulse
- o_minus_pulse  out  CH_NUM  one-cycle reverse-step pulse
- o_cnt  out  CH_NUM*CNT_W  position counters; channel n occupies bits [n*CNT_W +: CNT_W]
- o_err  out  CH_NUM  sticky illegal-transition flag

Behaviour:
- Reset (i_rst_n low at a clock edge): o_cnt=0, pulses=0, o_err=0, synchronisers=1, filter counters=0, per-channel primed flag=0. Reset asserted mid-motion aborts everything; no pulse is issued on reset exit.
- Synchroniser: 2 flip-flops each on A and B.
- Filter (A and B filtered independently): a synchronised value differing from the current filtered value must hold FILT_LEN consecutive cycles. The filtered value then updates on the FILT_LEN-th cycle. Any bounce restarts the count.
- Priming: once primed=0, the first FILT_LEN-stable filtered {A,B} after reset loads the previous-state register and sets primed. No count and no error occur on this load.
- Decode compares previous {A,B} with current {A,B}. Forward Gray sequence is 00->01->11->10->00. Reverse is the opposite.
- x4: every legal step counts.
- x2: only steps where B changes count.
- x1: only B-rising steps count. A=0 gives plus; A=1 gives minus.
- Illegal step (A and B change in the same cycle): no count, no pulse, o_err[n] set. Previous state still updates.
- Pulses are registered, one cycle wide. The counter updates in the same cycle as the pulse.
- Latency from a pin change to the pulse is exactly 2+FILT_LEN+1 cycles (7 at default).
- Counter arithmetic is modulo 2^CNT_W: 2^CNT_W-1 plus 1 gives 0, and 0 minus 1 gives all-ones.
- i_clr[n] zeroes the counter next cycle and wins over a simultaneous step. The pulse is still emitted.
- i_err_clr[n] clears o_err; a simultaneous new error wins (o_err stays 1).
- A change on i_mode takes effect on the next decode. The previous-state register is unaffected.
- Channels are fully independent. Any set of channels may pulse in the same cycle.

Optional Feature:
- QDEC_INDEX_EN defined: adds input i_coder_Z [CH_NUM] and output o_index_pulse [CH_NUM].
- Z is synchronised and filtered like A/B. A filtered Z rising edge zeroes the counter and gives a one-cycle o_index_pulse, with the same latency as A/B.
- If a step coincides with the Z edge, the counter becomes 0 (index wins); the step pulse is still emitted.
- i_clr has the same effect as the Z edge.
- Macro undefined: ports absent, no Z logic.

Decomposition:
- Package qdec_pkg: mode constants QDEC_MODE_X1=2'd0, QDEC_MODE_X2=2'd1, QDEC_MODE_X4=2'd2; Gray-state constants; a function for legal-step direction (+1/-1/0/illegal).
- Sub-module qdec_chan: one channel (sync, filter, decode, counter, error). It is instantiated CH_NUM times by a generate loop in quad_decoder_mc.

Test Plan:
- Reset then forward x4 sequence 00,01,11,10,00, each held 10 cycles, ch0 -> 4 plus pulses, o_cnt[0]=4, each pulse 7 cycles after its pin edge.
- Same forward sequence in x1 mode -> 1 plus pulse, cnt=1. Reverse full cycle in x2 -> 2 minus pulses, cnt=1-2=all-ones (wrap).
- 2-cycle glitch on B (FILT_LEN=4) -> no pulse, no count change. 4-cycle stable change -> exactly one pulse.
- A and B toggled together 00->11 -> o_err[0]=1, cnt unchanged. i_err_clr in the same cycle as a second illegal step -> o_err stays 1.
- cnt=5, i_clr[1] coincident with a plus step on ch1 -> cnt=0, plus pulse seen. ch2 stepping simultaneously is unaffected.
- With QDEC_INDEX_EN, cnt=37, Z rising -> cnt=0, o_index_pulse one cycle, 7-cycle latency.
